// File: rtl/c2s_mwr_requestor_if.sv
// Requestor bus bundle for the C2S MWr engine.
// Groups the descriptor, app stream, TLP arbiter/burst, payload and status signals.
interface c2s_mwr_requestor_if #(
  parameter int unsigned PCIE_CORE_DATA_WIDTH = 128
);
  logic [12:0]                     max_payload_size;
  logic                            desc_valid;
  logic                            desc_rdy;
  logic [63:0]                     desc_sys_addr;
  logic [31:0]                     desc_len;
  logic [PCIE_CORE_DATA_WIDTH-1:0] s_axis_tdata;
  logic                            s_axis_tvalid;
  logic                            s_axis_tlast;
  logic                            s_axis_tready;
  logic                            arbit_req_o;
  logic                            arbit_grnt_i;
  logic [12:0]                     burst_len_out_o;
  logic [63:0]                     burst_sys_addr_out_o;
  logic                            burst_dir_out_o;
  logic [7:0]                      burst_chan_o;
  logic [PCIE_CORE_DATA_WIDTH-1:0] mwr_data_o;
  logic                            mwr_data_valid_o;
  logic                            mwr_data_last_o;
  logic                            mwr_data_rdy_i;
  logic                            xfer_done_o;
  logic [31:0]                     xfer_bytes_o;
  logic                            len_err_o;
  logic                            busy_o;

  // Requestor side.
  modport master (
    input  max_payload_size, desc_valid, desc_sys_addr, desc_len,
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  arbit_grnt_i, mwr_data_rdy_i,
    output desc_rdy, s_axis_tready, arbit_req_o,
    output burst_len_out_o, burst_sys_addr_out_o, burst_dir_out_o, burst_chan_o,
    output mwr_data_o, mwr_data_valid_o, mwr_data_last_o,
    output xfer_done_o, xfer_bytes_o, len_err_o, busy_o
  );

  // Environment side: descriptor source, app stream, TLP engine.
  modport slave (
    output max_payload_size, desc_valid, desc_sys_addr, desc_len,
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output arbit_grnt_i, mwr_data_rdy_i,
    input  desc_rdy, s_axis_tready, arbit_req_o,
    input  burst_len_out_o, burst_sys_addr_out_o, burst_dir_out_o, burst_chan_o,
    input  mwr_data_o, mwr_data_valid_o, mwr_data_last_o,
    input  xfer_done_o, xfer_bytes_o, len_err_o, busy_o
  );
endinterface

// File: rtl/c2s_mwr_requestor.sv
// C2S write engine for one DMA channel: buffers app stream data, splits a descriptor
// into MPS / 4 KB bounded MWr bursts, arbitrates per burst and streams the payload.
module c2s_mwr_requestor #(
  parameter int unsigned CHAN_ID              = 0,
  parameter int unsigned PCIE_CORE_DATA_WIDTH = 128,
  parameter int unsigned FIFO_DEPTH_LOG2      = 8
) (
  input logic                 s_axi_clk,
  input logic                 s_axi_rst,
  c2s_mwr_requestor_if.master bus
);

  localparam int unsigned DATA_BYTES = PCIE_CORE_DATA_WIDTH / 8;
  localparam int unsigned BEAT_SHIFT = $clog2(DATA_BYTES);
  localparam int unsigned DEPTH      = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE = 1;

  typedef enum logic [2:0] {StIdle, StCalc, StWait, StReq, StData, StDone} state_e;

  state_e state_q, state_d;

  logic [63:0] addr_q, baddr_q;
  logic [31:0] rem_q, len_q, in_left_q, bytes_q;
  logic [12:0] blen_q, beat_q;
  logic        len_err_q, rdy_q;

  logic [PCIE_CORE_DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0]      wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]        cnt_q;

  logic [12:0] mps_eff, page_room, blen_calc, burst_beats;
  logic        accept, push, pop, last_beat, fifo_full, busy;

  assign fifo_full   = cnt_q[FIFO_DEPTH_LOG2];
  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign accept      = (state_q == StIdle) && rdy_q && bus.desc_valid;
  assign push        = bus.s_axis_tvalid && bus.s_axis_tready;
  assign pop         = (state_q == StData) && bus.mwr_data_rdy_i;
  assign burst_beats = blen_q >> BEAT_SHIFT;
  assign last_beat   = (beat_q == burst_beats - 13'd1);

  // Burst size: smallest of remaining bytes, effective MPS and room left in the 4 KB page.
  always_comb begin
    case (bus.max_payload_size)
      13'd128, 13'd256, 13'd512, 13'd1024, 13'd2048, 13'd4096: mps_eff = bus.max_payload_size;
      default: mps_eff = 13'd128;
    endcase
    page_room = 13'h1000 - {1'b0, addr_q[11:0]};
    blen_calc = (page_room < mps_eff) ? page_room : mps_eff;
    if (rem_q < {19'b0, blen_calc}) blen_calc = rem_q[12:0];
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = StCalc;
      StCalc: state_d = StWait;
      // Whole burst must be buffered so the TLP engine never starves mid-burst.
      StWait: if (32'(cnt_q) >= 32'(burst_beats)) state_d = StReq;
      StReq:  if (bus.arbit_grnt_i) state_d = StData;
      StData: if (pop && last_beat) state_d = (rem_q == {19'b0, blen_q}) ? StDone : StCalc;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge s_axi_clk or posedge s_axi_rst) begin
    if (s_axi_rst) state_q <= StIdle;
    else           state_q <= state_d;
  end

  // Descriptor, burst and FIFO bookkeeping.
  always_ff @(posedge s_axi_clk or posedge s_axi_rst) begin
    if (s_axi_rst) begin
      rdy_q     <= 1'b0;
      addr_q    <= '0;
      rem_q     <= '0;
      len_q     <= '0;
      in_left_q <= '0;
      len_err_q <= 1'b0;
      blen_q    <= '0;
      baddr_q   <= '0;
      beat_q    <= '0;
      bytes_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      rdy_q <= (state_d == StIdle);
      if (accept) begin
        addr_q    <= bus.desc_sys_addr;
        rem_q     <= bus.desc_len;
        len_q     <= bus.desc_len;
        in_left_q <= bus.desc_len >> BEAT_SHIFT;
        len_err_q <= 1'b0;
      end else if (push) begin
        in_left_q <= in_left_q - 32'd1;
        // Data is still accepted; only the marker mismatch is flagged.
        if (bus.s_axis_tlast != (in_left_q == 32'd1)) len_err_q <= 1'b1;
      end
      if (state_q == StCalc) begin
        blen_q  <= blen_calc;
        baddr_q <= addr_q;
        beat_q  <= '0;
      end
      if (pop) begin
        beat_q <= last_beat ? 13'd0 : beat_q + 13'd1;
        if (last_beat) begin
          addr_q <= addr_q + {51'b0, blen_q};
          rem_q  <= rem_q - {19'b0, blen_q};
        end
      end
      if (state_d == StDone && state_q == StData) bytes_q <= len_q;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload storage; contents need no reset since the pointers define validity.
  always_ff @(posedge s_axi_clk) begin
    if (push) mem[wr_ptr_q] <= bus.s_axis_tdata;
  end

  assign bus.desc_rdy             = rdy_q;
  assign bus.s_axis_tready        = busy && (in_left_q != 32'd0) && !fifo_full;
  assign bus.arbit_req_o          = (state_q == StReq);
  assign bus.burst_len_out_o      = blen_q;
  assign bus.burst_sys_addr_out_o = baddr_q;
  assign bus.burst_dir_out_o      = 1'b1;
  assign bus.burst_chan_o         = 8'(CHAN_ID);
  assign bus.mwr_data_valid_o     = (state_q == StData);
  // Gate the read port so idle/reset payload is zero rather than stale memory.
  assign bus.mwr_data_o           = (state_q == StData) ? mem[rd_ptr_q] : '0;
  assign bus.mwr_data_last_o      = (state_q == StData) && last_beat;
  assign bus.xfer_done_o          = (state_q == StDone);
  assign bus.xfer_bytes_o         = bytes_q;
  assign bus.len_err_o            = len_err_q;
  assign bus.busy_o               = busy;

endmodule

// File: tb/tb_c2s_mwr_requestor.sv
// Scoreboard bench for c2s_mwr_requestor: payload and planned bursts are queued as
// stimulus is driven and compared when the engine emits them.
module tb_c2s_mwr_requestor;
  localparam int unsigned W    = 128;
  localparam int unsigned DB   = W / 8;
  localparam int unsigned CHAN = 3;

  typedef struct {
    logic [63:0] addr;
    logic [12:0] len;
  } burst_t;

  logic s_axi_clk = 1'b0;
  logic s_axi_rst;
  always #5 s_axi_clk = ~s_axi_clk;

  c2s_mwr_requestor_if #(.PCIE_CORE_DATA_WIDTH(W)) bus ();

  c2s_mwr_requestor #(
    .CHAN_ID(CHAN),
    .PCIE_CORE_DATA_WIDTH(W),
    .FIFO_DEPTH_LOG2(8)
  ) dut (
    .s_axi_clk(s_axi_clk),
    .s_axi_rst(s_axi_rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] data_q[$];
  burst_t       burst_q[$];
  burst_t       cur;
  bit           in_burst = 0;
  bit           prev_done = 0;
  int           beat_idx = 0;
  int           gap_cnt = 0;
  int           done_cnt = 0;
  int           tot_beats = 0;
  int           req_in_stall = 0;
  int           grant_delay = 0;
  bit           rnd_rdy = 0;
  logic [31:0]  exp_bytes = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference burst split: min(remaining, effective MPS, bytes to page end).
  task automatic plan_bursts(input logic [63:0] addr, input logic [31:0] len,
                             input logic [12:0] mps);
    logic [63:0] a;
    logic [31:0] rem;
    int m, room, b;
    burst_t e;
    a = addr;
    rem = len;
    m = (mps inside {13'd128, 13'd256, 13'd512, 13'd1024, 13'd2048, 13'd4096}) ? int'(mps) : 128;
    while (rem != 0) begin
      room = 4096 - int'(a[11:0]);
      b = m;
      if (room < b) b = room;
      if (rem < 32'(b)) b = int'(rem);
      e.addr = a;
      e.len  = 13'(b);
      burst_q.push_back(e);
      a   = a + 64'(b);
      rem = rem - 32'(b);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_desc_rdy"}, bus.desc_rdy, 0);
    check({tag, "_tready"}, bus.s_axis_tready, 0);
    check({tag, "_req"}, bus.arbit_req_o, 0);
    check({tag, "_blen"}, bus.burst_len_out_o, 0);
    check({tag, "_baddr"}, bus.burst_sys_addr_out_o, 0);
    check({tag, "_dir"}, bus.burst_dir_out_o, 1);
    check({tag, "_chan"}, bus.burst_chan_o, CHAN);
    check({tag, "_data"}, bus.mwr_data_o, 0);
    check({tag, "_valid"}, bus.mwr_data_valid_o, 0);
    check({tag, "_last"}, bus.mwr_data_last_o, 0);
    check({tag, "_done"}, bus.xfer_done_o, 0);
    check({tag, "_bytes"}, bus.xfer_bytes_o, 0);
    check({tag, "_len_err"}, bus.len_err_o, 0);
    check({tag, "_busy"}, bus.busy_o, 0);
  endtask

  task automatic send_desc(input logic [63:0] addr, input logic [31:0] len);
    int cyc;
    cyc = 0;
    @(posedge s_axi_clk); #1;
    bus.desc_valid    = 1'b1;
    bus.desc_sys_addr = addr;
    bus.desc_len      = len;
    do begin
      @(negedge s_axi_clk);
      cyc++;
    end while (!bus.desc_rdy && cyc < 1000);
    if (!bus.desc_rdy) check("desc_accept_timeout", 0, 1);
    @(posedge s_axi_clk); #1;
    bus.desc_valid = 1'b0;
  endtask

  task automatic source(input int n, input int tlast_at, input int stall_at, input int stall_cyc);
    logic [W-1:0] d;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        bus.s_axis_tvalid = 1'b0;
        for (int k = 0; k < stall_cyc; k++) begin
          @(negedge s_axi_clk);
          if (bus.arbit_req_o) req_in_stall++;
        end
        @(posedge s_axi_clk); #1;
      end
      d = {$urandom, $urandom, $urandom, $urandom};
      bus.s_axis_tdata  = d;
      bus.s_axis_tlast  = (i + 1 == tlast_at);
      bus.s_axis_tvalid = 1'b1;
      do @(negedge s_axi_clk); while (!bus.s_axis_tready);
      data_q.push_back(d);
      @(posedge s_axi_clk); #1;
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic run_xfer(input logic [63:0] addr, input logic [31:0] len, input logic [12:0] mps,
                          input int tlast_at, input int stall_at, input int stall_cyc);
    int start, cyc;
    plan_bursts(addr, len, mps);
    exp_bytes = len;
    bus.max_payload_size = mps;
    start = done_cnt;
    send_desc(addr, len);
    check("len_err_clear_on_accept", bus.len_err_o, 0);
    check("busy_on_accept", bus.busy_o, 1);
    fork
      source(int'(len / DB), tlast_at, stall_at, stall_cyc);
    join_none
    cyc = 0;
    while (done_cnt == start && cyc < 20000) begin
      @(posedge s_axi_clk);
      cyc++;
    end
    #1;
    check("done_seen", done_cnt != start, 1);
    disable fork;
    bus.s_axis_tvalid = 1'b0;
    check("bursts_left", burst_q.size(), 0);
    check("beats_left", data_q.size(), 0);
    check("busy_after_done", bus.busy_o, 0);
    burst_q.delete();
    data_q.delete();
  endtask

  // Arbiter model: one-cycle grant after grant_delay cycles of request.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.arbit_grnt_i = 1'b0;
    forever begin
      @(posedge s_axi_clk); #1;
      bus.arbit_grnt_i = 1'b0;
      if (bus.arbit_req_o) begin
        if (wait_cnt >= grant_delay) begin
          bus.arbit_grnt_i = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // TLP engine ready: always ready or 50% random.
  initial begin
    bus.mwr_data_rdy_i = 1'b1;
    forever begin
      @(posedge s_axi_clk); #1;
      bus.mwr_data_rdy_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: bursts, payload ordering, last flag, gaps and done pulses.
  initial begin
    bit last_exp;
    forever begin
      @(negedge s_axi_clk);
      if (s_axi_rst) begin
        in_burst  = 0;
        prev_done = 0;
      end else begin
        if (bus.xfer_done_o) begin
          check("done_pulse_width", prev_done, 0);
          check("xfer_bytes", bus.xfer_bytes_o, exp_bytes);
          done_cnt++;
        end
        prev_done = bus.xfer_done_o;
        if (in_burst) begin
          if (!bus.mwr_data_valid_o) begin
            gap_cnt++;
          end else if (bus.mwr_data_rdy_i) begin
            last_exp = (beat_idx == int'(cur.len) / DB - 1);
            check("mwr_last", bus.mwr_data_last_o, last_exp);
            check("burst_addr_stable", bus.burst_sys_addr_out_o, cur.addr);
            if (data_q.size() == 0) check("data_underflow", 1, 0);
            else check("mwr_data", bus.mwr_data_o, data_q.pop_front());
            tot_beats++;
            beat_idx++;
            if (last_exp) in_burst = 0;
          end
        end else if (bus.mwr_data_valid_o) begin
          check("stray_valid", 1, 0);
        end
        if (bus.arbit_req_o && bus.arbit_grnt_i) begin
          if (burst_q.size() == 0) begin
            check("burst_extra", 1, 0);
          end else begin
            cur = burst_q.pop_front();
            check("burst_addr", bus.burst_sys_addr_out_o, cur.addr);
            check("burst_len", bus.burst_len_out_o, cur.len);
            check("burst_dir", bus.burst_dir_out_o, 1);
            in_burst = 1;
            beat_idx = 0;
          end
        end
      end
    end
  end

  initial begin
    int cyc, start_beats, done_before;
    s_axi_rst = 1'b1;
    bus.desc_valid       = 1'b0;
    bus.desc_sys_addr    = '0;
    bus.desc_len         = '0;
    bus.max_payload_size = 13'd256;
    bus.s_axis_tdata     = '0;
    bus.s_axis_tvalid    = 1'b0;
    bus.s_axis_tlast     = 1'b0;
    repeat (3) @(posedge s_axi_clk);
    #1;
    check_reset_outputs("rst");
    s_axi_rst = 1'b0;
    @(posedge s_axi_clk); #1;
    check("desc_rdy_idle", bus.desc_rdy, 1);

    // Two full MPS bursts.
    run_xfer(64'h1000, 32'd512, 13'd256, 32, -1, 0);
    // First burst clipped at the page end, second starts the new page.
    run_xfer(64'h0FC0, 32'd256, 13'd256, 16, -1, 0);
    // App stalls after 10 beats: no request until the whole burst is buffered.
    req_in_stall = 0;
    run_xfer(64'h2000, 32'd512, 13'd256, 32, 10, 40);
    check("no_req_while_underfilled", req_in_stall, 0);
    // Early tlast: flag sets, all beats still move; next accept clears it.
    run_xfer(64'h4000, 32'd512, 13'd256, 10, -1, 0);
    check("len_err_set", bus.len_err_o, 1);
    // Illegal MPS falls back to 128.
    run_xfer(64'h3000, 32'd256, 13'd300, 16, -1, 0);
    // Random back-pressure, slow grant, carry into bit 32.
    rnd_rdy = 1;
    grant_delay = 20;
    run_xfer(64'hFFFF_FFC0, 32'd128, 13'd128, 8, -1, 0);
    rnd_rdy = 0;
    grant_delay = 0;

    // Reset in the middle of a burst.
    plan_bursts(64'h6000, 32'd512, 13'd256);
    exp_bytes = 32'd512;
    bus.max_payload_size = 13'd256;
    start_beats = tot_beats;
    send_desc(64'h6000, 32'd512);
    fork
      source(32, 32, -1, 0);
    join_none
    cyc = 0;
    while (tot_beats < start_beats + 5 && cyc < 2000) begin
      @(posedge s_axi_clk);
      cyc++;
    end
    check("reached_data", tot_beats >= start_beats + 5, 1);
    done_before = done_cnt;
    #3;
    s_axi_rst = 1'b1;
    #1;
    disable fork;
    check_reset_outputs("midrst");
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    data_q.delete();
    burst_q.delete();
    repeat (3) @(posedge s_axi_clk);
    #1;
    s_axi_rst = 1'b0;
    repeat (2) @(posedge s_axi_clk);
    check("no_done_after_abort", done_cnt, done_before);
    run_xfer(64'h5000, 32'd256, 13'd256, 16, -1, 0);

    check("no_valid_gaps", gap_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
